kb_code_sequencer: RTL and testbench
====================================

// Module: kb_code_sequencer
// PURPOSE
//  Sequences the raw PS/2 scan-code byte stream from the keyboard receiver into ASCII characters.
//  Parses the F0 (break) and E0 (extended) prefixes and tracks Shift and Caps Lock state.
//  Uses the scan-to-ASCII lookup for each make code, applies case, and presents one
//  character on a valid/ready handshake to the downstream FIFO/UART/text path.
// PARAMETERS
//  PREFIX_TIMEOUT  2_500_000  cycles the FSM waits after an F0/E0 prefix before it aborts to IDLE (25 ms @ 100 MHz)
//  TO_W            $clog2(PREFIX_TIMEOUT+1)  width of the timeout counter (derived; do not override)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset, asynchronous, active-high
//  scan_data    in   8  received scan-code byte
//  scan_valid   in   1  1-cycle strobe: scan_data is valid (receiver done tick)
//  ascii_out    out  8  character to downstream
//  ascii_valid  out  1  ascii_out holds an unaccepted character
//  ascii_ready  in   1  downstream accepts; transfer = ascii_valid & ascii_ready
//  caps_on      out  1  Caps Lock state (for the LED / status display)
//  overflow     out  1  sticky: a make code was dropped because the output slot was full
//  ovf_clr      in   1  clears overflow (takes priority over a same-cycle set)
// BEHAVIOUR
//  Reset: state=IDLE; ascii_out=8'h00, ascii_valid=0, caps_on=0, overflow=0, shift flags=0, timeout counter=0.
//  FSM states: IDLE, BRK (seen F0), EXT (seen E0), EXT_BRK (seen E0 F0).
//   IDLE: F0->BRK; E0->EXT; 12/59 -> set lshift/rshift; 58 -> toggle caps_on; other -> emit(code); stay IDLE.
//   BRK: 12/59 -> clear lshift/rshift; any other -> discard; ->IDLE.
//   EXT: F0->EXT_BRK; 5A (keypad Enter) -> emit 8'h0D; else discard; ->IDLE.
//   EXT_BRK: any byte -> discard; ->IDLE.
//   Timeout: in BRK/EXT/EXT_BRK the counter increments each cycle without scan_valid; at PREFIX_TIMEOUT-1 -> IDLE
//            without an emit. The counter clears on every scan_valid and in IDLE.
//  emit(code): the LUT gives an uppercase letter, digit, punctuation, 20/0D/08, or 2A for an unmapped code.
//   If the LUT result is in 41..5A and (lshift|rshift)==caps_on -> add 8'h20 (lowercase); else pass it through unchanged.
//   ascii_out/ascii_valid are registered; ascii_valid rises on the cycle after the scan_valid strobe (latency 1).
//  Handshake: while ascii_valid=1 and ascii_ready=0, ascii_out is held stable. ascii_valid drops the cycle after the transfer.
//  Slot full: if an emit occurs while ascii_valid=1 and ascii_ready=0 -> the character is dropped and overflow<=1.
//   Emit in the same cycle as a transfer -> the new character loads and ascii_valid stays 1 (no bubble, no drop).
//  Prefix and modifier bytes never touch the output slot; they still update state while the slot is full.
//  scan_valid is sampled only on its strobe cycle. Back-to-back strobes on consecutive cycles are each processed.
//  A reset mid-sequence (e.g. after F0) returns to IDLE and clears every modifier.
// CONFIGURATION
//  KB_REPEAT_FILTER_EN defined: a 1-entry last_make register (reset 8'h00) is kept.
//   A non-modifier make code equal to last_make is discarded (typematic repeat).
//   A break of that code, or any different make, updates/clears last_make.
//  Not defined: every typematic repeat make code emits a character (auto-repeat passes through).
// STRUCTURE
//  Package kb_pkg: localparams SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59,
//   SC_CAPS=8'h58, SC_ENTER=8'h5A, ASCII_CR=8'h0D, CASE_OFS=8'h20, FSM state encodings.
//  Sub-module kb_scan_lut: combinational scan code -> uppercase ASCII (default 8'h2A). It is instantiated once on scan_data.
//  Top: FSM, modifier regs, timeout counter, output slot, overflow flag.
// TESTING
//  1 rst; send 1C, F0 1C, ascii_ready=1 -> exactly one 8'h61 ('a'), 1 cycle after the 1C strobe.
//  2 send 12, 1C, F0 12, 1C -> 8'h41 then 8'h61. Send 58, 1C -> caps_on=1, 8'h41. Send 12, 1C -> 8'h61.
//  3 ascii_ready=0; send 16, 1E -> ascii_out=8'h31 held, overflow=1. Pulse ovf_clr -> overflow=0.
//     Emit with ascii_ready=1 in the same cycle -> no drop.
//  4 send E0 5A -> 8'h0D. Send E0 75, E0 F0 75 -> nothing emitted. Send 29 -> 8'h20.
//  5 send F0, idle PREFIX_TIMEOUT cycles (bench PREFIX_TIMEOUT=16), send 1C -> 'a' emitted.
//     Send F0, assert rst mid-prefix -> IDLE, all outputs at reset values.
//  6 send 1C 1C 1C, F0 1C -> 3 chars without KB_REPEAT_FILTER_EN, 1 char with it. Unmapped 8'h07 -> 8'h2A.

Source files
------------

// File: rtl/kb_pkg.sv
// ============================================================================
// Module   : kb_pkg
// Brief    : Shared scan-code constants, FSM encodings and case helper for the
//            PS/2 keyboard code sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kb_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] CASE_OFS  = 8'h20;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Letters come out of the LUT uppercase; Shift and Caps Lock cancel each other.
  function automatic logic [7:0] apply_case(input logic [7:0] chr,
                                            input logic       shift,
                                            input logic       caps);
    if ((chr >= 8'h41) && (chr <= 8'h5A) && (shift == caps)) begin
      return chr + CASE_OFS;
    end
    return chr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kb_scan_lut.sv
// ============================================================================
// Module   : kb_scan_lut
// Brief    : Combinational PS/2 set-2 make code to uppercase ASCII lookup;
//            unmapped codes return '*' (8'h2A).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kb_scan_lut (
  input  logic [7:0] scan_code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h2A;
    case (scan_code_i)
      8'h1C: ascii_o = 8'h41; 8'h32: ascii_o = 8'h42; 8'h21: ascii_o = 8'h43;
      8'h23: ascii_o = 8'h44; 8'h24: ascii_o = 8'h45; 8'h2B: ascii_o = 8'h46;
      8'h34: ascii_o = 8'h47; 8'h33: ascii_o = 8'h48; 8'h43: ascii_o = 8'h49;
      8'h3B: ascii_o = 8'h4A; 8'h42: ascii_o = 8'h4B; 8'h4B: ascii_o = 8'h4C;
      8'h3A: ascii_o = 8'h4D; 8'h31: ascii_o = 8'h4E; 8'h44: ascii_o = 8'h4F;
      8'h4D: ascii_o = 8'h50; 8'h15: ascii_o = 8'h51; 8'h2D: ascii_o = 8'h52;
      8'h1B: ascii_o = 8'h53; 8'h2C: ascii_o = 8'h54; 8'h3C: ascii_o = 8'h55;
      8'h2A: ascii_o = 8'h56; 8'h1D: ascii_o = 8'h57; 8'h22: ascii_o = 8'h58;
      8'h35: ascii_o = 8'h59; 8'h1A: ascii_o = 8'h5A;
      8'h45: ascii_o = 8'h30; 8'h16: ascii_o = 8'h31; 8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33; 8'h25: ascii_o = 8'h34; 8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36; 8'h3D: ascii_o = 8'h37; 8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      8'h29: ascii_o = 8'h20; 8'h5A: ascii_o = 8'h0D; 8'h66: ascii_o = 8'h08;
      8'h41: ascii_o = 8'h2C; 8'h49: ascii_o = 8'h2E; 8'h4A: ascii_o = 8'h2F;
      8'h4C: ascii_o = 8'h3B; 8'h52: ascii_o = 8'h27; 8'h4E: ascii_o = 8'h2D;
      8'h55: ascii_o = 8'h3D; 8'h54: ascii_o = 8'h5B; 8'h5B: ascii_o = 8'h5D;
      8'h5D: ascii_o = 8'h5C; 8'h0E: ascii_o = 8'h60;
      default: ascii_o = 8'h2A;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/kb_code_sequencer.sv
// ============================================================================
// Module   : kb_code_sequencer
// Brief    : PS/2 scan-code stream to ASCII: F0/E0 prefix parsing, Shift and
//            Caps Lock tracking, one-entry valid/ready output slot.
//            Optional macro KB_REPEAT_FILTER_EN suppresses typematic repeats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kb_code_sequencer
  import kb_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_data,
  input  logic       scan_valid,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       caps_on,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int TO_W = $clog2(PREFIX_TIMEOUT + 1);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            caps_q, caps_d;
  logic [7:0]      ascii_q, ascii_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
`ifdef KB_REPEAT_FILTER_EN
  logic [7:0]      last_make_q, last_make_d;
`endif

  logic [7:0]      w_lut_chr;
  logic            w_timeout;
  logic            w_emit;
  logic [7:0]      w_emit_chr;

  kb_scan_lut u_scan_lut (
    .scan_code_i (scan_data),
    .ascii_o     (w_lut_chr)
  );

  assign w_timeout = (state_q != ST_IDLE) && !scan_valid &&
                     (to_cnt_q == TO_W'(PREFIX_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_data == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (scan_data == SC_EXT) begin
            state_d = ST_EXT;
          end
        end
        ST_EXT:  state_d = (scan_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    caps_d     = caps_q;
    w_emit     = 1'b0;
    w_emit_chr = apply_case(w_lut_chr, lshift_q | rshift_q, caps_q);
`ifdef KB_REPEAT_FILTER_EN
    last_make_d = last_make_q;
`endif
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          case (scan_data)
            SC_BREAK, SC_EXT: ;
            SC_LSHIFT: lshift_d = 1'b1;
            SC_RSHIFT: rshift_d = 1'b1;
            SC_CAPS:   caps_d   = ~caps_q;
            default: begin
`ifdef KB_REPEAT_FILTER_EN
              w_emit      = (scan_data != last_make_q);
              last_make_d = scan_data;
`else
              w_emit = 1'b1;
`endif
            end
          endcase
        end
        ST_BRK: begin
          if (scan_data == SC_LSHIFT) begin
            lshift_d = 1'b0;
          end else if (scan_data == SC_RSHIFT) begin
            rshift_d = 1'b0;
          end
`ifdef KB_REPEAT_FILTER_EN
          else if (scan_data == last_make_q) begin
            last_make_d = 8'h00;
          end
`endif
        end
        ST_EXT: begin
          if (scan_data == SC_ENTER) begin
            w_emit     = 1'b1;
            w_emit_chr = ASCII_CR;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(1);
    if (scan_valid || (state_q == ST_IDLE) || w_timeout) begin
      to_cnt_d = '0;
    end
  end

  // A transfer frees the slot in the same cycle, so a simultaneous emit loads.
  always_comb begin
    ascii_d = ascii_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (valid_q && ascii_ready) begin
      valid_d = 1'b0;
    end
    if (w_emit) begin
      if (valid_q && !ascii_ready) begin
        ovf_d = 1'b1;
      end else begin
        ascii_d = w_emit_chr;
        valid_d = 1'b1;
      end
    end
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      caps_q   <= 1'b0;
      ascii_q  <= 8'h00;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef KB_REPEAT_FILTER_EN
      last_make_q <= 8'h00;
`endif
    end else begin
      to_cnt_q <= to_cnt_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      caps_q   <= caps_d;
      ascii_q  <= ascii_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
`ifdef KB_REPEAT_FILTER_EN
      last_make_q <= last_make_d;
`endif
    end
  end

  assign ascii_out   = ascii_q;
  assign ascii_valid = valid_q;
  assign caps_on     = caps_q;
  assign overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_kb_code_sequencer.sv
// ============================================================================
// Module   : tb_kb_code_sequencer
// Brief    : Directed self-checking bench for kb_code_sequencer with a
//            cycle-level reference model and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kb_code_sequencer;

  localparam int PTO = 16;
`ifdef KB_REPEAT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  localparam logic [15:0] MAP [47] = '{
    16'h1C41, 16'h3242, 16'h2143, 16'h2344, 16'h2445, 16'h2B46, 16'h3447,
    16'h3348, 16'h4349, 16'h3B4A, 16'h424B, 16'h4B4C, 16'h3A4D, 16'h314E,
    16'h444F, 16'h4D50, 16'h1551, 16'h2D52, 16'h1B53, 16'h2C54, 16'h3C55,
    16'h2A56, 16'h1D57, 16'h2258, 16'h3559, 16'h1A5A, 16'h4530, 16'h1631,
    16'h1E32, 16'h2633, 16'h2534, 16'h2E35, 16'h3636, 16'h3D37, 16'h3E38,
    16'h4639, 16'h2920, 16'h5A0D, 16'h6608, 16'h412C, 16'h492E, 16'h4A2F,
    16'h4C3B, 16'h5227, 16'h4E2D, 16'h553D, 16'h5B5D
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_data = 8'h00;
  logic       scan_valid = 1'b0;
  logic       ascii_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       caps_on;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;

  kb_code_sequencer #(.PREFIX_TIMEOUT(PTO)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_data   (scan_data),
    .scan_valid  (scan_valid),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .caps_on     (caps_on),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  logic [7:0] tbl [256];
  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 8'h2A;
    for (int i = 0; i < 47; i++) tbl[MAP[i][15:8]] = MAP[i][7:0];
    tbl[8'h5D] = 8'h5C;
    tbl[8'h54] = 8'h5B;
    tbl[8'h0E] = 8'h60;
  end

  // Reference model: prefix kind, idle cycles since prefix, modifiers, slot.
  int         m_pfx = 0;   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
  int         m_idle = 0;
  bit         m_ls = 0, m_rs = 0, m_caps = 0, m_ovf = 0, m_val = 0;
  logic [7:0] m_out = 8'h00, m_last = 8'h00, m_chr;
  bit         m_emit, m_xfer;

  function automatic logic [7:0] model_chr(input logic [7:0] code, input bit shifted, input bit caps);
    logic [7:0] c = tbl[code];
    bit letter = (c >= 8'h41) && (c <= 8'h5A);
    if (letter && (shifted == caps)) c = c + 8'h20;
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pfx = 0; m_idle = 0; m_ls = 0; m_rs = 0; m_caps = 0;
      m_ovf = 0; m_val = 0; m_out = 8'h00; m_last = 8'h00;
    end else begin
      m_xfer = m_val && ascii_ready;
      m_emit = 0;
      m_chr  = 8'h00;
      if (scan_valid) begin
        m_idle = 0;
        if (m_pfx == 0) begin
          if (scan_data == 8'hF0) m_pfx = 1;
          else if (scan_data == 8'hE0) m_pfx = 2;
          else if (scan_data == 8'h12) m_ls = 1;
          else if (scan_data == 8'h59) m_rs = 1;
          else if (scan_data == 8'h58) m_caps = !m_caps;
          else begin
            m_emit = !(FILTER && scan_data == m_last);
            m_chr  = model_chr(scan_data, m_ls || m_rs, m_caps);
            m_last = scan_data;
          end
        end else if (m_pfx == 1) begin
          if (scan_data == 8'h12) m_ls = 0;
          else if (scan_data == 8'h59) m_rs = 0;
          else if (scan_data == m_last) m_last = 8'h00;
          m_pfx = 0;
        end else if (m_pfx == 2) begin
          if (scan_data == 8'h5A) begin m_emit = 1; m_chr = 8'h0D; end
          m_pfx = (scan_data == 8'hF0) ? 3 : 0;
        end else begin
          m_pfx = 0;
        end
      end else if (m_pfx != 0) begin
        m_idle++;
        if (m_idle == PTO) begin m_pfx = 0; m_idle = 0; end
      end
      if (m_xfer) m_val = 0;
      if (m_emit) begin
        if (m_val) m_ovf = 1;
        else begin m_out = m_chr; m_val = 1; end
      end
      if (ovf_clr) m_ovf = 0;
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("cyc_valid", {7'd0, ascii_valid}, {7'd0, m_val});
    cmp("cyc_out", ascii_out, m_out);
    cmp("cyc_caps", {7'd0, caps_on}, {7'd0, m_caps});
    cmp("cyc_ovf", {7'd0, overflow}, {7'd0, m_ovf});
  end

  always @(posedge clk) if (ascii_valid && ascii_ready) xfers++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1; scan_data = b;
    tick();
    scan_valid = 1'b0;
  endtask

  // Character must be presented the cycle right after its strobe.
  task automatic send_chk(input string nm, input logic [7:0] b, input logic [7:0] exp);
    send(b);
    @(negedge clk);
    cmp({nm, "_valid"}, {7'd0, ascii_valid}, 8'd1);
    cmp({nm, "_out"}, ascii_out, exp);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int x0;
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("rst_out", ascii_out, 8'h00);
    cmp("rst_valid", {7'd0, ascii_valid}, 8'd0);
    tick();

    // 1: plain make/break
    x0 = xfers;
    send_chk("t1_a", 8'h1C, 8'h61);
    send(8'hF0); send(8'h1C); idle(3);
    cmp("t1_count", 8'(xfers - x0), 8'd1);

    // 2: shift and caps
    send(8'h12); send_chk("t2_A", 8'h1C, 8'h41); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send_chk("t2_a", 8'h1C, 8'h61); send(8'hF0); send(8'h1C);
    send(8'h58); send_chk("t2_capsA", 8'h1C, 8'h41);
    cmp("t2_caps_on", {7'd0, caps_on}, 8'd1);
    send(8'hF0); send(8'h1C);
    send(8'h59); send_chk("t2_capsShift", 8'h1C, 8'h61); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h59); send(8'h58); send(8'hF0); send(8'h58);
    cmp("t2_caps_off", {7'd0, caps_on}, 8'd0);

    // 3: full slot, overflow, clear priority, same-cycle transfer
    ascii_ready = 1'b0;
    send_chk("t3_one", 8'h16, 8'h31);
    send(8'h1E); idle(2);
    @(negedge clk);
    cmp("t3_held", ascii_out, 8'h31);
    cmp("t3_ovf", {7'd0, overflow}, 8'd1);
    tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    @(negedge clk);
    cmp("t3_ovf_clr", {7'd0, overflow}, 8'd0);
    tick();
    ascii_ready = 1'b1; scan_valid = 1'b1; scan_data = 8'h26;
    tick();
    scan_valid = 1'b0; ascii_ready = 1'b0;
    @(negedge clk);
    cmp("t3_noDrop_out", ascii_out, 8'h33);
    cmp("t3_noDrop_ovf", {7'd0, overflow}, 8'd0);
    tick();
    ovf_clr = 1'b1; send(8'h25); ovf_clr = 1'b0;
    @(negedge clk);
    cmp("t3_clr_prio", {7'd0, overflow}, 8'd0);
    cmp("t3_held2", ascii_out, 8'h33);
    tick();
    ascii_ready = 1'b1; idle(2);

    // 4: extended codes
    send(8'hE0); send_chk("t4_cr", 8'h5A, 8'h0D);
    x0 = xfers;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(3);
    cmp("t4_none", 8'(xfers - x0), 8'd0);
    send_chk("t4_space", 8'h29, 8'h20);

    // 5: prefix timeout boundary, then reset mid-prefix
    x0 = xfers;
    send(8'hF0); idle(PTO - 1); send(8'h1C); idle(3);
    cmp("t5_before_to", 8'(xfers - x0), 8'd0);
    send(8'hF0); idle(PTO); send_chk("t5_after_to", 8'h1C, 8'h61);
    send(8'hF0); send(8'h1C);
    send(8'h12); send(8'h58); send(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    cmp("t5_rst_caps", {7'd0, caps_on}, 8'd0);
    cmp("t5_rst_valid", {7'd0, ascii_valid}, 8'd0);
    cmp("t5_rst_out", ascii_out, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    send_chk("t5_post_rst", 8'h1C, 8'h61);
    send(8'hF0); send(8'h1C);

    // 6: typematic repeat, unmapped code
    x0 = xfers;
    scan_valid = 1'b1; scan_data = 8'h1C;
    idle(3);
    scan_valid = 1'b0;
    send(8'hF0); send(8'h1C); idle(3);
    cmp("t6_repeat", 8'(xfers - x0), FILTER ? 8'd1 : 8'd3);
    send_chk("t6_unmapped", 8'h07, 8'h2A);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
